// File: rtl/ext_pipe.sv
// Immediate / load-data extender with a 2-entry output FIFO, valid/ready on both sides,
// sticky misalignment flag and a transfer counter.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_addr_lo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ext,
  output logic              out_misalign,
  output logic              err_sticky,
  input  logic              err_clr,
  output logic [15:0]       op_count
);

  if (DATA_W < 32 || DATA_W < IMM_W + SHIFT) begin : g_bad_params
    $error("ext_pipe: illegal parameters, need DATA_W >= 32 and DATA_W >= IMM_W + SHIFT");
  end

  function automatic logic [DATA_W-1:0] sext_imm(logic [IMM_W-1:0] v);
    logic signed [IMM_W-1:0] s;
    s = v;
    return DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] sext_b(logic [7:0] v);
    logic signed [7:0] s;
    s = v;
    return DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] sext_h(logic [15:0] v);
    logic signed [15:0] s;
    s = v;
    return DATA_W'(s);
  endfunction

  logic [1:0]        count;
  logic [DATA_W-1:0] hd_ext, tl_ext;
  logic              hd_mis, tl_mis;
  logic [DATA_W-1:0] new_ext;
  logic              new_mis;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              acc, xfer;

  assign in_ready     = (count != 2'd2);
  assign out_valid    = (count != 2'd0);
  assign out_ext      = hd_ext;
  assign out_misalign = hd_mis;
  assign acc          = in_valid & in_ready;
  assign xfer         = out_valid & out_ready;

  assign lane_b = in_data[8*in_addr_lo +: 8];
  assign lane_h = in_data[16*in_addr_lo[1] +: 16];

  // Result is fully formed at accept; the buffer only ever moves finished entries.
  always_comb begin
    new_ext = '0;
    new_mis = 1'b0;
    case (in_op)
      3'd0: new_ext = sext_imm(in_imm);
      3'd1: new_ext = DATA_W'(in_imm);
      3'd2: new_ext = DATA_W'(in_imm) << (DATA_W - IMM_W);
      3'd3: new_ext = sext_imm(in_imm) << SHIFT;
      3'd4: new_ext = sext_b(lane_b);
      3'd5: new_ext = DATA_W'(lane_b);
      default: begin
        if (in_addr_lo[0]) new_mis = 1'b1;
        else if (in_op == 3'd6) new_ext = sext_h(lane_h);
        else new_ext = DATA_W'(lane_h);
      end
    endcase
  end

  // Buffer stage: head slot feeds the outputs, tail slot holds the second entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= 2'd0;
      hd_ext     <= '0;
      hd_mis     <= 1'b0;
      tl_ext     <= '0;
      tl_mis     <= 1'b0;
      op_count   <= 16'd0;
      err_sticky <= 1'b0;
    end else begin
      if (acc && (count == 2'd0 || (count == 2'd1 && xfer))) begin
        hd_ext <= new_ext;
        hd_mis <= new_mis;
      end else if (xfer && count == 2'd2) begin
        hd_ext <= tl_ext;
        hd_mis <= tl_mis;
      end
      if (acc && count == 2'd1 && !xfer) begin
        tl_ext <= new_ext;
        tl_mis <= new_mis;
      end
      case ({acc, xfer})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (xfer) op_count <= op_count + 16'd1;
      if (acc && new_mis) err_sticky <= 1'b1;
      else if (err_clr)   err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: queue scoreboard filled on accept, drained on output transfer.
module tb_ext_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_imm;
  logic [31:0] in_data;
  logic [1:0]  in_addr_lo;
  logic        out_valid, out_ready;
  logic [31:0] out_ext;
  logic        out_misalign, err_sticky, err_clr;
  logic [15:0] op_count;

  typedef struct packed {
    logic        mis;
    logic [31:0] ext;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [31:0] cur_ext;
  logic        cur_mis;

  ext_pipe #(.IMM_W(16), .DATA_W(32), .SHIFT(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_data(in_data), .in_addr_lo(in_addr_lo),
    .out_valid(out_valid), .out_ready(out_ready), .out_ext(out_ext),
    .out_misalign(out_misalign), .err_sticky(err_sticky), .err_clr(err_clr),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshakes are resolved at the falling edge, where all DUT outputs are settled.
  task automatic tick();
    exp_t h;
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (out_valid && out_ready) begin
      vectors++;
      assert (q.size() != 0) else begin
        miscompares++;
        $error("FAIL underflow: observed output with empty scoreboard, ext %h", out_ext);
      end
      if (q.size() != 0) begin
        h = q.pop_front();
        chk("out_ext", out_ext, h.ext);
        chk("out_misalign", {31'd0, out_misalign}, {31'd0, h.mis});
        exp_cnt++;
      end
    end
    if (in_valid && in_ready) q.push_back({cur_mis, cur_ext});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] imm, input logic [31:0] data,
                       input logic [1:0] addr, input logic [31:0] e_ext, input logic e_mis);
    in_valid   = 1'b1;
    in_op      = op;
    in_imm     = imm;
    in_data    = data;
    in_addr_lo = addr;
    cur_ext    = e_ext;
    cur_mis    = e_mis;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_imm = 16'd0; in_data = 32'd0;
    in_addr_lo = 2'd0; out_ready = 1'b0; err_clr = 1'b0; cur_ext = 32'd0; cur_mis = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_ext", out_ext, 32'd0);
    chk("rst_out_mis", {31'd0, out_misalign}, 32'd0);
    chk("rst_err", {31'd0, err_sticky}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Immediate modes, back to back with the consumer always ready
    out_ready = 1'b1;
    drive(3'd0, 16'h8004, 32'd0, 2'd0, 32'hFFFF8004, 1'b0); tick();
    chk("latency", {31'd0, out_valid}, 32'd1);
    drive(3'd1, 16'h8004, 32'd0, 2'd0, 32'h00008004, 1'b0); tick();
    drive(3'd2, 16'h8004, 32'd0, 2'd0, 32'h80040000, 1'b0); tick();
    drive(3'd3, 16'h8004, 32'd0, 2'd0, 32'hFFFE0010, 1'b0); tick();

    // Load lanes
    drive(3'd4, 16'd0, 32'h80F1_7F82, 2'd0, 32'hFFFFFF82, 1'b0); tick();
    drive(3'd5, 16'd0, 32'h80F1_7F82, 2'd3, 32'h00000080, 1'b0); tick();
    drive(3'd6, 16'd0, 32'h80F1_7F82, 2'd2, 32'hFFFF80F1, 1'b0); tick();
    drive(3'd7, 16'd0, 32'h80F1_7F82, 2'd0, 32'h00007F82, 1'b0); tick();
    drive(3'd4, 16'd0, 32'h80F1_7F82, 2'd1, 32'h0000007F, 1'b0); tick();
    drive(3'd5, 16'd0, 32'h80F1_7F82, 2'd2, 32'h000000F1, 1'b0); tick();
    chk("err_clean", {31'd0, err_sticky}, 32'd0);

    // Misalignment and sticky error (set beats clear)
    drive(3'd6, 16'd0, 32'h80F1_7F82, 2'd1, 32'h00000000, 1'b1); tick();
    chk("err_set", {31'd0, err_sticky}, 32'd1);
    err_clr = 1'b1;
    drive(3'd7, 16'd0, 32'h80F1_7F82, 2'd3, 32'h00000000, 1'b1); tick();
    chk("err_set_wins", {31'd0, err_sticky}, 32'd1);
    in_valid = 1'b0; tick();
    chk("err_cleared", {31'd0, err_sticky}, 32'd0);
    err_clr = 1'b0;
    tick();
    chk("op_count_a", {16'd0, op_count}, {16'd0, exp_cnt});

    // Backpressure: two fit, third waits, head held
    out_ready = 1'b0;
    drive(3'd1, 16'h1111, 32'd0, 2'd0, 32'h00001111, 1'b0); tick();
    drive(3'd1, 16'h2222, 32'd0, 2'd0, 32'h00002222, 1'b0); tick();
    drive(3'd1, 16'h3333, 32'd0, 2'd0, 32'h00003333, 1'b0); tick();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("head_stable", out_ext, 32'h00001111);
    tick();
    chk("head_stable2", out_ext, 32'h00001111);
    out_ready = 1'b1;
    tick(); tick(); in_valid = 1'b0; tick();
    chk("op_count_bp", {16'd0, op_count}, {16'd0, exp_cnt});

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    drive(3'd0, 16'h0001, 32'd0, 2'd0, 32'h00000001, 1'b0); tick();
    drive(3'd0, 16'h0002, 32'd0, 2'd0, 32'h00000002, 1'b0); tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_op_count", {16'd0, op_count}, 32'd0);
    chk("mid_rst_out_ext", out_ext, 32'd0);
    q.delete();
    exp_cnt = 16'd0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    drive(3'd2, 16'hABCD, 32'd0, 2'd0, 32'hABCD0000, 1'b0); tick();
    chk("post_rst_latency", {31'd0, out_valid}, 32'd1);
    chk("post_rst_ext", out_ext, 32'hABCD0000);
    in_valid = 1'b0; tick();

    // Counter wrap
    for (int i = 0; i < 70000 && exp_cnt != 16'hFFFF; i++) begin
      drive(3'd1, 16'(i), 32'd0, 2'd0, {16'd0, 16'(i)}, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    chk("op_count_ffff", {16'd0, op_count}, 32'h0000FFFF);
    tick();
    chk("op_count_wrap", {16'd0, op_count}, {16'd0, exp_cnt});
    chk("op_count_zero", {16'd0, op_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
